// File: rtl/coil_pulse_gen.sv
// Coil pulse generator: one H-bridge pulse (drive then dead time) per rising edge of tick.
// Optional overrun flag/interrupt source enabled by defining COIL_PULSE_OVERRUN_IRQ_EN.
module coil_pulse_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        coil_a,
  output logic        coil_b,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StDrive, StDead} state_e;

  state_e      state_q;
  logic        tick_q, armed_q;
  logic [3:0]  ctrl_q;
  logic [15:0] on_time_q, dead_time_q;
  logic [31:0] count_q;
  logic        done_q;
  logic        overrun;
  logic [15:0] on_cnt_q, dead_cnt_q, dead_len_q;
  logic [15:0] rdata_d;

  logic wr_en, wr_status, wr_ctrl, wr_on, wr_dead, wr_count;
  logic tick_edge, enable_next, start, pulse_end;

  assign wr_en     = chipselect && !write_n;
  assign wr_status = wr_en && (address == 3'd0);
  assign wr_ctrl   = wr_en && (address == 3'd1);
  assign wr_on     = wr_en && (address == 3'd2);
  assign wr_dead   = wr_en && (address == 3'd3);
  assign wr_count  = wr_en && ((address == 3'd4) || (address == 3'd5));

  // armed_q blocks a tick that was already high when reset released.
  assign tick_edge   = tick && !tick_q && armed_q;
  assign enable_next = wr_ctrl ? writedata[0] : ctrl_q[0];
  assign start       = (state_q == StIdle) && tick_edge && ctrl_q[0] && (on_time_q != 16'd0);
  assign pulse_end   = (state_q == StDead) && (dead_cnt_q == 16'd1);

  assign busy = (state_q != StIdle);
  assign irq  = ctrl_q[2] && (done_q || overrun);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      coil_a     <= 1'b0;
      coil_b     <= 1'b0;
      on_cnt_q   <= '0;
      dead_cnt_q <= '0;
      dead_len_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StDrive;
            coil_a     <= !ctrl_q[3];
            coil_b     <= ctrl_q[3];
            on_cnt_q   <= on_time_q;
            dead_len_q <= (dead_time_q == 16'd0) ? 16'd1 : dead_time_q;
          end
        end
        StDrive: begin
          // Disabling mid-pulse cuts the drive short but still runs the full dead time.
          if (!enable_next || (on_cnt_q == 16'd1)) begin
            state_q    <= StDead;
            coil_a     <= 1'b0;
            coil_b     <= 1'b0;
            dead_cnt_q <= dead_len_q;
          end else begin
            on_cnt_q <= on_cnt_q - 16'd1;
          end
        end
        StDead: begin
          if (dead_cnt_q == 16'd1) state_q <= StIdle;
          else dead_cnt_q <= dead_cnt_q - 16'd1;
        end
        default: begin
          state_q <= StIdle;
          coil_a  <= 1'b0;
          coil_b  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= 1'b0;
      armed_q     <= 1'b0;
      ctrl_q      <= '0;
      on_time_q   <= 16'd1000;
      dead_time_q <= 16'd50;
      count_q     <= '0;
      done_q      <= 1'b0;
      readdata    <= '0;
    end else begin
      tick_q   <= tick;
      armed_q  <= armed_q || !tick;
      readdata <= rdata_d;
      if (wr_ctrl) ctrl_q <= writedata[3:0];
      else if (pulse_end && ctrl_q[1]) ctrl_q[3] <= !ctrl_q[3];
      if (wr_on) on_time_q <= writedata;
      if (wr_dead) dead_time_q <= writedata;
      if (wr_count) count_q <= '0;
      else if (pulse_end) count_q <= count_q + 32'd1;
      if (pulse_end) done_q <= 1'b1;
      else if (wr_status) done_q <= 1'b0;
    end
  end

`ifdef COIL_PULSE_OVERRUN_IRQ_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else if (busy && tick_edge) overrun_q <= 1'b1;
    else if (wr_status) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (address)
      3'd0:    rdata_d = {13'd0, overrun, done_q, busy};
      3'd1:    rdata_d = {12'd0, ctrl_q};
      3'd2:    rdata_d = on_time_q;
      3'd3:    rdata_d = dead_time_q;
      3'd4:    rdata_d = count_q[15:0];
      3'd5:    rdata_d = count_q[31:16];
      default: rdata_d = '0;
    endcase
  end

endmodule

// File: tb/tb_coil_pulse_gen.sv
// Bench for coil_pulse_gen: interval-based pulse model checked every cycle, directed
// literal scenarios, then randomized register/tick traffic.
module tb_coil_pulse_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        coil_a, coil_b, busy, irq;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cmp_on = 1'b0;

  always #5 clk = ~clk;

  coil_pulse_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .coil_a    (coil_a),
    .coil_b    (coil_b),
    .busy      (busy),
    .irq       (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: registers as plain values, the current pulse as cycle intervals
  // [p_first, p_dlast] drive and (p_dlast, p_end] dead.
  longint      cyc = 0;
  longint      p_first = 1, p_dlast = 0, p_end = 0, p_dlen = 1;
  logic [3:0]  m_ctrl = 4'd0;
  logic [15:0] m_on = 16'd1000, m_dead = 16'd50, m_rd = 16'd0;
  logic [31:0] m_count = 32'd0;
  logic        m_done = 1'b0, m_over = 1'b0, m_tq = 1'b0, m_armed = 1'b0, m_pol = 1'b0;
  logic        e_a = 1'b0, e_b = 1'b0, e_busy = 1'b0, e_irq = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    longint c0, n;
    logic   busy0, drive0, wr, edge_s, en_next, pend, start;
    if (!reset_n) begin
      m_ctrl = 4'd0; m_on = 16'd1000; m_dead = 16'd50; m_count = 32'd0;
      m_done = 1'b0; m_over = 1'b0; m_tq = 1'b0; m_armed = 1'b0; m_pol = 1'b0;
      m_rd = 16'd0; p_first = 1; p_dlast = 0; p_end = 0;
      e_a = 1'b0; e_b = 1'b0; e_busy = 1'b0; e_irq = 1'b0;
      cyc = cyc + 1;
    end else begin
      c0      = cyc;
      n       = cyc + 1;
      busy0   = (c0 >= p_first) && (c0 <= p_end);
      drive0  = busy0 && (c0 <= p_dlast);
      wr      = chipselect && !write_n;
      edge_s  = tick && !m_tq && m_armed;
      en_next = (wr && address == 3'd1) ? writedata[0] : m_ctrl[0];
      pend    = busy0 && (c0 == p_end);
      start   = !busy0 && edge_s && m_ctrl[0] && (m_on != 16'd0);
      case (address)
        3'd0:    m_rd = {13'd0, m_over, m_done, busy0};
        3'd1:    m_rd = {12'd0, m_ctrl};
        3'd2:    m_rd = m_on;
        3'd3:    m_rd = m_dead;
        3'd4:    m_rd = m_count[15:0];
        3'd5:    m_rd = m_count[31:16];
        default: m_rd = 16'd0;
      endcase
      if (drive0 && !en_next) begin
        p_dlast = c0;
        p_end   = c0 + p_dlen;
      end
      if (start) begin
        p_first = n;
        p_dlast = n + longint'(m_on) - 1;
        p_dlen  = (m_dead == 16'd0) ? 1 : longint'(m_dead);
        p_end   = p_dlast + p_dlen;
        m_pol   = m_ctrl[3];
      end
`ifdef COIL_PULSE_OVERRUN_IRQ_EN
      if (busy0 && edge_s) m_over = 1'b1;
      else if (wr && address == 3'd0) m_over = 1'b0;
`endif
      if (pend) m_done = 1'b1;
      else if (wr && address == 3'd0) m_done = 1'b0;
      if (wr && (address == 3'd4 || address == 3'd5)) m_count = 32'd0;
      else if (pend) m_count = m_count + 32'd1;
      if (wr && address == 3'd1) m_ctrl = writedata[3:0];
      else if (pend && m_ctrl[1]) m_ctrl[3] = ~m_ctrl[3];
      if (wr && address == 3'd2) m_on = writedata;
      if (wr && address == 3'd3) m_dead = writedata;
      m_tq    = tick;
      m_armed = m_armed | !tick;
      cyc     = n;
      e_busy  = (n >= p_first) && (n <= p_end);
      e_a     = e_busy && (n <= p_dlast) && !m_pol;
      e_b     = e_busy && (n <= p_dlast) && m_pol;
      e_irq   = m_ctrl[2] && (m_done || m_over);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("coil_a", coil_a, e_a);
      chk("coil_b", coil_b, e_b);
      chk("busy", busy, e_busy);
      chk("irq", irq, e_irq);
      chk("readdata", readdata, m_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address = a;
    step();
    d = readdata;
  endtask

  task automatic fire(input int cycles, output int na, output int nb, output int nbz);
    na = 0; nb = 0; nbz = 0;
    tick = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      tick = 1'b0;
      na  += int'(coil_a);
      nb  += int'(coil_b);
      nbz += int'(busy);
    end
  endtask

  initial begin
    logic [15:0] d;
    int na, nb, nbz;
    step();
    cmp_on = 1'b1;
    step();
    chk("rst_coil_a", coil_a, 0);
    chk("rst_coil_b", coil_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_readdata", readdata, 0);
    reset_n = 1'b1;
    step(); step();
    rd(3'd2, d); chk("rst_on_time", d, 16'd1000);
    rd(3'd3, d); chk("rst_dead_time", d, 16'd50);
    rd(3'd1, d); chk("rst_control", d, 16'd0);
    rd(3'd4, d); chk("rst_count", d, 16'd0);

    // Basic pulse: A for 4 cycles, 2 dead cycles
    wr(3'd1, 16'h5); wr(3'd2, 16'd4); wr(3'd3, 16'd2);
    tick = 1'b1;
    chk("pulse_busy_r0", busy, 0);
    for (int r = 1; r <= 8; r++) begin
      step();
      tick = 1'b0;
      chk($sformatf("pulse_coil_a_r%0d", r), coil_a, (r <= 4) ? 1 : 0);
      chk($sformatf("pulse_coil_b_r%0d", r), coil_b, 0);
      chk($sformatf("pulse_busy_r%0d", r), busy, (r <= 6) ? 1 : 0);
    end
    chk("pulse_irq", irq, 1);
    rd(3'd0, d); chk("pulse_status", d, 16'h0002);
    rd(3'd4, d); chk("pulse_count", d, 16'd1);

    // Second tick during drive: pulse length unaffected
    wr(3'd2, 16'd10);
    na = 0;
    tick = 1'b1;
    for (int r = 1; r <= 25; r++) begin
      step();
      tick = (r == 5);
      na += int'(coil_a);
    end
    chk("overrun_len", na, 10);
    rd(3'd0, d);
`ifdef COIL_PULSE_OVERRUN_IRQ_EN
    chk("overrun_status", d, 16'h0006);
`else
    chk("overrun_status", d, 16'h0002);
`endif
    wr(3'd0, 16'd0);
    rd(3'd0, d); chk("status_clear", d, 16'h0000);

    // Alternating polarity A, B, A
    wr(3'd4, 16'd0); wr(3'd1, 16'h3); wr(3'd2, 16'd3);
    for (int i = 0; i < 3; i++) begin
      fire(20, na, nb, nbz);
      chk($sformatf("alt_a_%0d", i), na, (i == 1) ? 0 : 3);
      chk($sformatf("alt_b_%0d", i), nb, (i == 1) ? 3 : 0);
    end
    rd(3'd4, d); chk("alt_count", d, 16'd3);

    // ON_TIME=0 ignored; DEAD_TIME=0 gives one dead cycle
    wr(3'd1, 16'h1); wr(3'd2, 16'd0);
    fire(10, na, nb, nbz);
    chk("zero_on_busy", nbz, 0);
    rd(3'd4, d); chk("zero_on_count", d, 16'd3);
    wr(3'd2, 16'd2); wr(3'd3, 16'd0);
    fire(10, na, nb, nbz);
    chk("zero_dead_busy", nbz, 3);
    chk("zero_dead_a", na, 2);
    rd(3'd4, d); chk("zero_dead_count", d, 16'd4);

    // Disable at drive cycle 3
    wr(3'd2, 16'd8); wr(3'd3, 16'd2);
    tick = 1'b1;
    step(); tick = 1'b0;
    step(); step();
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'd0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    chk("abort_coil_a", coil_a, 0);
    chk("abort_busy_d1", busy, 1);
    step(); chk("abort_busy_d2", busy, 1);
    step(); chk("abort_idle", busy, 0);
    rd(3'd4, d); chk("abort_count", d, 16'd5);

    // Reset mid-drive with tick held high across release
    wr(3'd1, 16'h1); wr(3'd2, 16'd20);
    tick = 1'b1;
    step(); step(); step();
    chk("prerst_coil_a", coil_a, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_coil_a", coil_a, 0);
    chk("async_rst_busy", busy, 0);
    step(); step();
    reset_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      chk($sformatf("held_tick_busy_%0d", r), busy, 0);
    end
    rd(3'd2, d); chk("rst2_on_time", d, 16'd1000);
    rd(3'd3, d); chk("rst2_dead_time", d, 16'd50);
    rd(3'd1, d); chk("rst2_control", d, 16'd0);
    tick = 1'b0;
    wr(3'd1, 16'h1); wr(3'd2, 16'd2); wr(3'd3, 16'd1);
    fire(6, na, nb, nbz);
    chk("rearm_a", na, 2);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) tick = ~tick;
      if ($urandom_range(0, 9) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin
            address   = 3'd1;
            writedata = {12'd0, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0)};
          end
          4, 5: begin address = 3'd2; writedata = 16'($urandom_range(0, 10)); end
          6, 7: begin address = 3'd3; writedata = 16'($urandom_range(0, 4)); end
          8: begin address = 3'd0; writedata = 16'($urandom); end
          default: begin address = 3'(4 + $urandom_range(0, 1)); writedata = 16'($urandom); end
        endcase
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
        address    = 3'($urandom_range(0, 7));
        writedata  = 16'($urandom);
      end
      step();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
